// File: rtl/mux_key_table_if.sv
// rtl/mux_key_table_if.sv - lookup request/response handshake bundle for mux_key_table
// The master issues keyed lookups and drains responses; the slave is the table.
interface mux_key_table_if #(
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8,
  parameter int IDX_W    = 2
);
  logic                req_valid;
  logic                req_ready;
  logic [KEY_LEN-1:0]  req_key;
  logic [DATA_LEN-1:0] default_out;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_LEN-1:0] resp_data;
  logic                resp_hit;
  logic [IDX_W-1:0]    resp_idx;

  modport master (
    output req_valid, req_key, default_out, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_hit, resp_idx
  );

  modport slave (
    input  req_valid, req_key, default_out, resp_ready,
    output req_ready, resp_valid, resp_data, resp_hit, resp_idx
  );
endinterface

// File: rtl/mux_key_table.sv
// rtl/mux_key_table.sv - runtime-programmable key/data lookup table with registered response
// Maintenance (clr > inv > wr) and lookups share one clock; lookups see pre-update table state.
module mux_key_table #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 8,
  parameter int HAS_DEFAULT = 1,
  localparam int IDX_W      = (NR_KEY > 2) ? $clog2(NR_KEY) : 1,
  localparam int CNT_W      = $clog2(NR_KEY + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                inv_en,
  input  logic [KEY_LEN-1:0]  inv_key,
  input  logic                wr_en,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  mux_key_table_if.slave      bus,
  output logic [CNT_W-1:0]    count,
  output logic                full
);

  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [NR_KEY-1:0]   valid_q;
  logic [NR_KEY-1:0]   valid_d;
  logic [NR_KEY-1:0]   ent_we;
  logic [IDX_W-1:0]    rr_q;
  logic [IDX_W-1:0]    rr_d;
  logic [CNT_W-1:0]    count_d;

  logic                lk_hit;
  logic [IDX_W-1:0]    lk_idx;
  logic [DATA_LEN-1:0] lk_data;
  logic                wr_hit;
  logic [IDX_W-1:0]    wr_hit_idx;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    wr_idx;
  logic                accept;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    lk_hit     = 1'b0;
    lk_idx     = '0;
    lk_data    = '0;
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == bus.req_key)) begin
        lk_hit  = 1'b1;
        lk_idx  = IDX_W'(i);
        lk_data = data_q[i];
      end
      if (valid_q[i] && (key_q[i] == wr_key)) begin
        wr_hit     = 1'b1;
        wr_hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Write target: in-place update, else lowest free slot, else round-robin victim.
  always_comb begin
    wr_idx = rr_q;
    if (wr_hit) begin
      wr_idx = wr_hit_idx;
    end else if (free_found) begin
      wr_idx = free_idx;
    end
  end

  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    ent_we  = '0;
    if (clr) begin
      valid_d = '0;
      rr_d    = '0;
    end else if (inv_en) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (valid_q[i] && (key_q[i] == inv_key)) begin
          valid_d[i] = 1'b0;
        end
      end
    end else if (wr_en) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          ent_we[i]  = 1'b1;
          valid_d[i] = 1'b1;
        end
      end
      if (!wr_hit && !free_found) begin
        rr_d = (rr_q == IDX_W'(NR_KEY - 1)) ? '0 : rr_q + 1'b1;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rr_q    <= '0;
      count   <= '0;
      full    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      count   <= count_d;
      full    <= (count_d == CNT_W'(NR_KEY));
    end
  end

  // Key/data payload carries no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NR_KEY; i++) begin
      if (ent_we[i]) begin
        key_q[i]  <= wr_key;
        data_q[i] <= wr_data;
      end
    end
  end

  assign bus.req_ready = !bus.resp_valid || bus.resp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_hit   <= 1'b0;
      bus.resp_idx   <= '0;
    end else if (accept) begin
      bus.resp_valid <= 1'b1;
      bus.resp_hit   <= lk_hit;
      bus.resp_idx   <= lk_idx;
      if (lk_hit) begin
        bus.resp_data <= lk_data;
      end else if (HAS_DEFAULT != 0) begin
        bus.resp_data <= bus.default_out;
      end else begin
        bus.resp_data <= '0;
      end
    end else if (bus.resp_ready) begin
      bus.resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_key_table.sv
// tb/tb_mux_key_table.sv - scoreboard bench for mux_key_table (default and zero-miss variants)
module tb_mux_key_table;
  localparam int NK = 4;
  localparam int KL = 4;
  localparam int DL = 8;
  localparam int IW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          inv_en = 1'b0;
  logic [KL-1:0] inv_key = '0;
  logic          wr_en = 1'b0;
  logic [KL-1:0] wr_key = '0;
  logic [DL-1:0] wr_data = '0;
  logic [CW-1:0] count_a, count_b;
  logic          full_a, full_b;

  mux_key_table_if #(.KEY_LEN(KL), .DATA_LEN(DL), .IDX_W(IW)) bus_a ();
  mux_key_table_if #(.KEY_LEN(KL), .DATA_LEN(DL), .IDX_W(IW)) bus_b ();

  mux_key_table #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inv_en(inv_en), .inv_key(inv_key),
    .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data), .bus(bus_a.slave),
    .count(count_a), .full(full_a)
  );

  mux_key_table #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inv_en(inv_en), .inv_key(inv_key),
    .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data), .bus(bus_b.slave),
    .count(count_b), .full(full_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DL-1:0] data;
    logic          hit;
    logic [IW-1:0] idx;
  } resp_t;

  resp_t q_a[$];
  resp_t q_b[$];
  resp_t e_a, e_b;
  int errors = 0;
  int checks = 0;
  int pops_a = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_a.resp_valid && bus_a.resp_ready) begin
      pops_a++;
      if (q_a.size() == 0) begin
        chk("a_unexpected_resp", 32'd1, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        chk("a_resp_data", 32'(bus_a.resp_data), 32'(e_a.data));
        chk("a_resp_hit", 32'(bus_a.resp_hit), 32'(e_a.hit));
        chk("a_resp_idx", 32'(bus_a.resp_idx), 32'(e_a.idx));
      end
    end
    if (rst_n && bus_b.resp_valid && bus_b.resp_ready) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_resp", 32'd1, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        chk("b_resp_data", 32'(bus_b.resp_data), 32'(e_b.data));
        chk("b_resp_hit", 32'(bus_b.resp_hit), 32'(e_b.hit));
        chk("b_resp_idx", 32'(bus_b.resp_idx), 32'(e_b.idx));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [KL-1:0] k, input logic [DL-1:0] d);
    bus_a.req_valid = v;  bus_a.req_key = k;  bus_a.default_out = d;
    bus_b.req_valid = v;  bus_b.req_key = k;  bus_b.default_out = d;
  endtask

  task automatic set_rdy(input logic r);
    bus_a.resp_ready = r;
    bus_b.resp_ready = r;
  endtask

  task automatic expect_resp(input logic hit, input logic [IW-1:0] idx,
                             input logic [DL-1:0] data, input logic [DL-1:0] dflt);
    q_a.push_back(hit ? {data, 1'b1, idx} : {dflt, 1'b0, 2'd0});
    q_b.push_back(hit ? {data, 1'b1, idx} : {8'h00, 1'b0, 2'd0});
  endtask

  task automatic lookup(input logic [KL-1:0] k, input logic [DL-1:0] dflt, input logic hit,
                        input logic [IW-1:0] idx, input logic [DL-1:0] data);
    set_req(1'b1, k, dflt);
    expect_resp(hit, idx, data, dflt);
    step();
    set_req(1'b0, k, dflt);
  endtask

  task automatic wr(input logic [KL-1:0] k, input logic [DL-1:0] d);
    wr_en = 1'b1; wr_key = k; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic inv(input logic [KL-1:0] k);
    inv_en = 1'b1; inv_key = k;
    step();
    inv_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [KL-1:0] sk  [8];
    logic          sh  [8];
    logic [IW-1:0] si  [8];
    logic [DL-1:0] sd  [8];
    int            p0;

    set_req(1'b0, '0, '0);
    set_rdy(1'b1);
    repeat (2) step();
    chk("rst_resp_valid", 32'(bus_a.resp_valid), 32'd0);
    chk("rst_resp_data", 32'(bus_a.resp_data), 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_req_ready", 32'(bus_a.req_ready), 32'd1);
    #3 rst_n = 1'b1;
    step();

    wr(4'h3, 8'h11);
    wr(4'h7, 8'h22);
    wr(4'h9, 8'h33);
    chk("count_3", 32'(count_a), 32'd3);
    lookup(4'h7, 8'h00, 1'b1, 2'd1, 8'h22);
    chk("latency_1", 32'(bus_a.resp_valid), 32'd1);
    lookup(4'h5, 8'hEE, 1'b0, 2'd0, 8'h00);

    wr(4'h7, 8'h44);
    chk("update_count", 32'(count_a), 32'd3);
    lookup(4'h7, 8'h00, 1'b1, 2'd1, 8'h44);
    inv(4'h3);
    chk("inv_count", 32'(count_a), 32'd2);
    wr(4'hA, 8'h55);
    chk("reinstall_count", 32'(count_a), 32'd3);
    lookup(4'hA, 8'h00, 1'b1, 2'd0, 8'h55);
    lookup(4'h3, 8'h3C, 1'b0, 2'd0, 8'h00);

    wr(4'h1, 8'h66);
    chk("fill_count", 32'(count_a), 32'd4);
    chk("fill_full", 32'(full_a), 32'd1);
    wr(4'hB, 8'hB1);
    chk("full_b", 32'(full_a), 32'd1);
    wr(4'hC, 8'hC1);
    wr(4'hD, 8'hD1);
    wr(4'hE, 8'hE1);
    chk("full_e", 32'(full_a), 32'd1);
    wr(4'hF, 8'hF1);
    chk("wrap_count", 32'(count_a), 32'd4);
    chk("wrap_full", 32'(full_b), 32'd1);
    lookup(4'hF, 8'h00, 1'b1, 2'd0, 8'hF1);
    lookup(4'hE, 8'h00, 1'b1, 2'd3, 8'hE1);
    lookup(4'hB, 8'h0B, 1'b0, 2'd0, 8'h00);
    lookup(4'hA, 8'h0A, 1'b0, 2'd0, 8'h00);
    lookup(4'h7, 8'h07, 1'b0, 2'd0, 8'h00);
    lookup(4'hC, 8'h00, 1'b1, 2'd1, 8'hC1);
    step();

    // Output stage held while the table changes underneath it.
    set_rdy(1'b0);
    set_req(1'b1, 4'hD, 8'h00);
    expect_resp(1'b1, 2'd2, 8'hD1, 8'h00);
    step();
    set_req(1'b1, 4'hC, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("hold_req_ready", 32'(bus_a.req_ready), 32'd0);
      chk("hold_resp_valid", 32'(bus_a.resp_valid), 32'd1);
      chk("hold_resp_data", 32'(bus_a.resp_data), 32'hD1);
      chk("hold_resp_idx", 32'(bus_a.resp_idx), 32'd2);
      if (i == 0) begin
        wr_en = 1'b1; wr_key = 4'hD; wr_data = 8'hD7;
      end
      step();
      wr_en = 1'b0;
    end
    set_rdy(1'b1);
    expect_resp(1'b1, 2'd1, 8'hC1, 8'h00);
    step();
    set_req(1'b0, 4'h0, 8'h00);
    step();
    chk("hold_count", 32'(count_a), 32'd4);

    sk = '{4'hF, 4'hC, 4'hD, 4'hE, 4'hB, 4'h0, 4'hF, 4'h2};
    sh = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    si = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    sd = '{8'hF1, 8'hC1, 8'hD7, 8'hE1, 8'h00, 8'h00, 8'hF1, 8'h00};
    p0 = pops_a;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, sk[i], 8'h80 + 8'(i));
      expect_resp(sh[i], si[i], sd[i], 8'h80 + 8'(i));
      step();
    end
    set_req(1'b0, 4'h0, 8'h00);
    step();
    chk("stream_pops", 32'(pops_a - p0), 32'd8);

    // Same-cycle write and lookup of key 5: lookup sees the old (missing) state.
    wr_en = 1'b1; wr_key = 4'h5; wr_data = 8'h99;
    set_req(1'b1, 4'h5, 8'h5A);
    expect_resp(1'b0, 2'd0, 8'h00, 8'h5A);
    step();
    wr_en = 1'b0;
    set_req(1'b0, 4'h0, 8'h00);
    lookup(4'h5, 8'h00, 1'b1, 2'd1, 8'h99);
    lookup(4'hC, 8'h0C, 1'b0, 2'd0, 8'h00);

    clr = 1'b1; inv_en = 1'b1; inv_key = 4'hF; wr_en = 1'b1; wr_key = 4'h6; wr_data = 8'h66;
    step();
    clr = 1'b0; inv_en = 1'b0; wr_en = 1'b0;
    chk("clr_count", 32'(count_a), 32'd0);
    chk("clr_full", 32'(full_a), 32'd0);
    lookup(4'h6, 8'h36, 1'b0, 2'd0, 8'h00);
    lookup(4'hF, 8'h33, 1'b0, 2'd0, 8'h00);
    wr(4'h3, 8'h12);
    chk("post_clr_count", 32'(count_b), 32'd1);
    lookup(4'h3, 8'h00, 1'b1, 2'd0, 8'h12);
    step();

    set_rdy(1'b0);
    lookup(4'h3, 8'h00, 1'b1, 2'd0, 8'h12);
    chk("pre_rst_valid", 32'(bus_a.resp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid_a", 32'(bus_a.resp_valid), 32'd0);
    chk("async_rst_valid_b", 32'(bus_b.resp_valid), 32'd0);
    chk("async_rst_data", 32'(bus_a.resp_data), 32'd0);
    chk("async_rst_count", 32'(count_a), 32'd0);
    q_a.delete();
    q_b.delete();
    set_rdy(1'b1);
    #3 rst_n = 1'b1;
    repeat (3) step();
    chk("no_stale_resp", 32'(bus_a.resp_valid), 32'd0);
    lookup(4'h3, 8'h77, 1'b0, 2'd0, 8'h00);
    step();
    step();
    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
